data_memory: RTL and testbench

Data-side memory and memory-mapped I/O stage that sits directly downstream of the RV32I core. It consumes the core's memory request signals (read address, write address, write data, write enable, func3) and returns load data one cycle later. It performs byte-lane write masking, load sign/zero extension, and hosts a small MMIO register window (LED output register and free-running micro/millisecond counters). Instruction fetch and data loads share its single read port.

---
 rtl/data_memory.sv | 157 +++++++++++++++
 tb/tb_data_memory.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Data-side RAM plus MMIO window (LED register and, when
//                MMIO_TIMERS_EN is defined, free-running micros/millis
//                counters). Byte-lane store masking and registered load
//                extension with one cycle of read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
    parameter int DEPTH_WORDS = 2048,
    parameter     INIT_FILE   = "",
    parameter int CLK_HZ      = 12000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data,
    output logic [7:0]  leds
);

    localparam int          C_ADDR_W      = $clog2(DEPTH_WORDS);
    localparam logic [29:0] C_LED_WORD    = 30'h3FFF_FFFF;
    localparam logic [29:0] C_MICROS_WORD = 30'h3FFF_FFFE;
    localparam logic [29:0] C_MILLIS_WORD = 30'h3FFF_FFFD;

    if ((CLK_HZ % 1000000) != 0 || CLK_HZ < 1000000) begin : g_clk_hz_check
        $error("data_memory: CLK_HZ must be a nonzero multiple of 1000000");
    end
    if ((1 << C_ADDR_W) != DEPTH_WORDS) begin : g_depth_check
        $error("data_memory: DEPTH_WORDS must be a power of two");
    end

    logic [31:0]         r_mem [DEPTH_WORDS];
    logic [7:0]          r_leds;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic                w_wr_ram;
    logic                w_rd_ram;
    logic [C_ADDR_W-1:0] w_wr_idx;
    logic [C_ADDR_W-1:0] w_rd_idx;
    logic [31:0]         w_rd_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;

    assign w_wr_ram = (write_address[31:C_ADDR_W+2] == '0);
    assign w_rd_ram = (read_address[31:C_ADDR_W+2] == '0);
    assign w_wr_idx = write_address[C_ADDR_W+1:2];
    assign w_rd_idx = read_address[C_ADDR_W+1:2];

    // Store data is replicated across lanes so each byte enable picks the right slice.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = write_data;
        case (funct3)
            3'b000: begin
                w_be    = 4'b0001 << write_address[1:0];
                w_wdata = {4{write_data[7:0]}};
            end
            3'b001: begin
                w_be    = write_address[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_data[15:0]}};
            end
            3'b010:  w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // RAM writes are intentionally independent of reset.
    always_ff @(posedge clk) begin
        if (write_enable && w_wr_ram) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_wr_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds <= 8'h00;
        end else if (write_enable && (write_address[31:2] == C_LED_WORD) && w_be[0]) begin
            r_leds <= w_wdata[7:0];
        end
    end

`ifdef MMIO_TIMERS_EN
    localparam int C_DIV   = CLK_HZ / 1000000;
    localparam int C_PRE_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;

    logic [C_PRE_W-1:0] r_pre;
    logic [9:0]         r_us;
    logic [31:0]        r_micros;
    logic [31:0]        r_millis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre    <= '0;
            r_us     <= 10'd0;
            r_micros <= 32'd0;
            r_millis <= 32'd0;
        end else if (r_pre == C_PRE_W'(C_DIV - 1)) begin
            r_pre    <= '0;
            r_micros <= r_micros + 32'd1;
            if (r_us == 10'd999) begin
                r_us     <= 10'd0;
                r_millis <= r_millis + 32'd1;
            end else begin
                r_us <= r_us + 10'd1;
            end
        end else begin
            r_pre <= r_pre + C_PRE_W'(1);
        end
    end
`endif

    always_comb begin
        w_rd_word = 32'd0;
        if (w_rd_ram) begin
            w_rd_word = r_mem[w_rd_idx];
        end else if (read_address[31:2] == C_LED_WORD) begin
            w_rd_word = {24'd0, r_leds};
`ifdef MMIO_TIMERS_EN
        end else if (read_address[31:2] == C_MICROS_WORD) begin
            w_rd_word = r_micros;
        end else if (read_address[31:2] == C_MILLIS_WORD) begin
            w_rd_word = r_millis;
`endif
        end
    end

    assign w_byte = w_rd_word[{read_address[1:0], 3'b000} +: 8];
    assign w_half = read_address[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data <= 32'd0;
        end else begin
            case (funct3)
                3'b000:  read_data <= {{24{w_byte[7]}}, w_byte};
                3'b100:  read_data <= {24'd0, w_byte};
                3'b001:  read_data <= {{16{w_half[15]}}, w_half};
                3'b101:  read_data <= {16'd0, w_half};
                default: read_data <= w_rd_word;
            endcase
        end
    end

    assign leds = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory
//  Description : Scoreboard bench for data_memory: directed and random
//                loads/stores against a byte-level memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    localparam int DEPTH  = 2048;
    localparam int CLK_HZ = 2000000;
    localparam int DIV    = CLK_HZ / 1000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic [31:0] read_address = 32'd0;
    logic [31:0] write_address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] read_data;
    logic [7:0]  leds;

    data_memory #(
        .DEPTH_WORDS (DEPTH),
        .INIT_FILE   (""),
        .CLK_HZ      (CLK_HZ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (write_enable),
        .read_address  (read_address),
        .write_address (write_address),
        .write_data    (write_data),
        .funct3        (funct3),
        .read_data     (read_data),
        .leds          (leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic [7:0]  led;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] m_mem [DEPTH];
    logic [7:0]  m_led = 8'h00;
    longint      m_cyc = 0;

    // Clock edges seen since reset was last released.
    always @(posedge clk) m_cyc = reset ? 0 : m_cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        if (addr < 32'(DEPTH * 4)) return m_mem[addr / 4];
        if (addr >= 32'hFFFF_FFFC) return {24'd0, m_led};
`ifdef MMIO_TIMERS_EN
        if (addr >= 32'hFFFF_FFF8) return 32'(m_cyc / DIV);
        if (addr >= 32'hFFFF_FFF4) return 32'(m_cyc / (DIV * 1000));
`endif
        return 32'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = model_word(addr);
        b = 8'(w >> (8 * addr[1:0]));
        h = 16'(w >> (16 * addr[1]));
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        logic       en;
        logic [7:0] val;
        for (int k = 0; k < 4; k++) begin
            en  = (f3 == 3'd2) || (f3 == 3'd1 && (k / 2) == int'(addr[1])) ||
                  (f3 == 3'd0 && k == int'(addr[1:0]));
            val = (f3 == 3'd0) ? data[7:0] : (f3 == 3'd1) ? data[8*(k%2) +: 8] : data[8*k +: 8];
            if (en) begin
                if (addr < 32'(DEPTH * 4)) m_mem[addr / 4][8*k +: 8] = val;
                else if (addr >= 32'hFFFF_FFFC && k == 0) m_led = val;
            end
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [2:0] f3, input string name);
        exp_t e;
        @(negedge clk);
        write_enable  = we;
        read_address  = ra;
        write_address = wa;
        write_data    = wd;
        funct3        = f3;
        e.rd = model_load(ra, f3);
        if (we) model_store(wa, wd, f3);
        e.led  = m_led;
        e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)  return 32'($urandom_range(0, 1023));
        if (r == 7) return 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
        if (r == 8) return 32'hFFFF_FFF4 | 32'($urandom_range(0, 7));
        return 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
    endfunction

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.name, " read_data"}, read_data, mon_e.rd);
            check({mon_e.name, " leds"}, {24'd0, leds}, {24'd0, mon_e.led});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset read_data", read_data, 32'd0);
        check("reset leds", {24'd0, leds}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 256; i++)
            issue(1'b1, 32'hFFFF_FFFC, 32'(i * 4), $urandom, 3'd2, "fill");

        issue(1'b1, 32'hFFFF_FFFC, 32'h100, 32'h80FF7F01, 3'd2, "sw 0x100");
        issue(1'b0, 32'h100, 32'h0, 32'h0, 3'd0, "lb 0x100");
        issue(1'b0, 32'h101, 32'h0, 32'h0, 3'd0, "lb 0x101");
        issue(1'b0, 32'h102, 32'h0, 32'h0, 3'd0, "lb 0x102");
        issue(1'b0, 32'h103, 32'h0, 32'h0, 3'd0, "lb 0x103");
        issue(1'b0, 32'h103, 32'h0, 32'h0, 3'd4, "lbu 0x103");
        issue(1'b1, 32'hFFFF_FFFC, 32'h200, 32'h0, 3'd2, "sw 0x200");
        issue(1'b1, 32'hFFFF_FFFC, 32'h202, 32'h0000BEEF, 3'd1, "sh 0x202");
        issue(1'b0, 32'h200, 32'h0, 32'h0, 3'd2, "lw 0x200");
        issue(1'b0, 32'h202, 32'h0, 32'h0, 3'd1, "lh 0x202");
        issue(1'b0, 32'h202, 32'h0, 32'h0, 3'd5, "lhu 0x202");
        issue(1'b1, 32'hFFFF_FFFC, 32'h300, 32'hAAAAAAAA, 3'd2, "sw 0x300 old");
        issue(1'b1, 32'h300, 32'h300, 32'h12345678, 3'd2, "same-cycle rw 0x300");
        issue(1'b0, 32'h300, 32'h0, 32'h0, 3'd2, "lw 0x300 new");
        issue(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000005A, 3'd0, "sb led");
        issue(1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 3'd2, "lw led");
        issue(1'b0, 32'h8000_0000, 32'h0, 32'h0, 3'd2, "lw unmapped");
        issue(1'b1, 32'hFFFF_FFFC, 32'h8000_0100, 32'hDEADBEEF, 3'd2, "sw unmapped");
        issue(1'b0, 32'h100, 32'h0, 32'h0, 3'd2, "lw 0x100 after unmapped sw");

        for (int i = 0; i < 600; i++)
            issue(1'($urandom_range(0, 1)), pick_addr(), pick_addr(), $urandom,
                  3'($urandom_range(0, 7)), "random");

        issue(1'b1, 32'hFFFF_FFFC, 32'h100, 32'hCAFEF00D, 3'd2, "sw 0x100 pre-reset");
        issue(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000005A, 3'd0, "sb led pre-reset");
        issue(1'b0, 32'h100, 32'h0, 32'h0, 3'd2, "lw 0x100 pre-reset");
        @(negedge clk);
        write_enable = 1'b0;
        read_address = 32'hFFFF_FFFC;
        #1 reset = 1'b1;
        #1;
        check("async reset read_data", read_data, 32'd0);
        check("async reset leds", {24'd0, leds}, 32'd0);
        m_led = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(1'b0, 32'h100, 32'h0, 32'h0, 3'd2, "lw 0x100 after reset");
        while (m_cyc < 1999)
            issue(1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 3'd2, "idle");
        issue(1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0, 3'd2, "micros at 2000");
        issue(1'b0, 32'hFFFF_FFF4, 32'h0, 32'h0, 3'd2, "millis at 2001");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
